// File: rtl/gpr_file_sb.sv
// gpr_file_sb: general-purpose register file with two combinational read
// ports, one registered write port, optional write-to-read bypass, a
// per-register pending-write scoreboard and a sequenced bulk-clear sweep.
// Addresses with the MSB set belong to the peripheral space and never hit.
module gpr_file_sb #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 4,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [WIDTH-1:0]  rd_data1,
   output logic [WIDTH-1:0]  rd_data2,
   output logic              rd_hit1,
   output logic              rd_hit2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              rsv_ok,
   output logic [DEPTH-1:0]  busy_vec,
   input  logic              clr_req,
   output logic              clr_busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {
      IDLE,
      SWEEP
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] mem [DEPTH];

   logic [IDX_W-1:0] rd_idx1;
   logic [IDX_W-1:0] rd_idx2;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rsv_idx;
   logic             wr_ok;

   // An address is a GPR when it is outside the peripheral space and below DEPTH.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (a[ADDR_W-1] == 1'b0) && ({1'b0, a[ADDR_W-2:0]} < DEPTH_A);
   endfunction

   assign rd_idx1 = rd_addr1[IDX_W-1:0];
   assign rd_idx2 = rd_addr2[IDX_W-1:0];
   assign wr_idx  = wr_addr[IDX_W-1:0];
   assign rsv_idx = rsv_addr[IDX_W-1:0];

   assign rd_hit1 = in_range(rd_addr1);
   assign rd_hit2 = in_range(rd_addr2);

   // Writes and reservations are locked out for the whole sweep.
   assign wr_ok  = wr_en & in_range(wr_addr) & ~clr_busy;
   assign rsv_ok = rsv_en & in_range(rsv_addr) & ~busy_vec[rsv_idx] & ~clr_busy;

   // Busy reflects registered scoreboard state only; bypass never masks it.
   assign rd_busy1 = rd_hit1 & busy_vec[rd_idx1];
   assign rd_busy2 = rd_hit2 & busy_vec[rd_idx2];

   // Read port 1: zero on a miss, forwarded write data on a same-cycle hit.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      rd_data1 = '0;
      if (rd_hit1) begin
         if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
         end else begin
            rd_data1 = mem[rd_idx1];
         end
      end
   end

   // Read port 2: same selection as port 1.
   always_comb begin
      rd_data2 = '0;
      if (rd_hit2) begin
         if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
         end else begin
            rd_data2 = mem[rd_idx2];
         end
      end
   end

   // Clear sequencer: IDLE waits for clr_req, SWEEP walks idx 0..DEPTH-1 once.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         clr_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clr_req) begin
                  state    <= SWEEP;
                  idx      <= '0;
                  clr_busy <= 1'b1;
               end
            end
            SWEEP: begin
               if (idx == LAST_IDX) begin
                  state    <= IDLE;
                  idx      <= '0;
                  clr_busy <= 1'b0;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               idx      <= '0;
               clr_busy <= 1'b0;
            end
         endcase
      end
   end

   // Register storage and scoreboard: sweep clear, else write then reservation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the array is reset explicitly because reset must zero every GPR, which forces flops rather than RAM.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         busy_vec <= '0;
      end else if (clr_busy) begin
         mem[idx]      <= '0;
         busy_vec[idx] <= 1'b0;
      end else begin
         if (wr_ok) begin
            mem[wr_idx]      <= wr_data;
            busy_vec[wr_idx] <= 1'b0;
         end
         // A same-cycle reservation is a new pending writer and overrides the clear above.
         if (rsv_ok) begin
            busy_vec[rsv_idx] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gpr_file_sb.sv
// Testbench for gpr_file_sb: directed scenarios plus randomized traffic
// compared against a behavioural model. Two instances share all inputs:
// one with bypass enabled and one without.
module tb_gpr_file_sb;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr, rsv_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              wr_en, rsv_en, clr_req;

   logic [WIDTH-1:0]  rd_data1, rd_data2;
   logic              rd_hit1, rd_hit2, rd_busy1, rd_busy2, rsv_ok, clr_busy;
   logic [DEPTH-1:0]  busy_vec;

   logic [WIDTH-1:0]  rd_data1_nb, rd_data2_nb;
   logic              rd_hit1_nb, rd_hit2_nb, rd_busy1_nb, rd_busy2_nb, rsv_ok_nb, clr_busy_nb;
   logic [DEPTH-1:0]  busy_vec_nb;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   logic [WIDTH-1:0] m_mem [DEPTH];
   bit               m_busy [DEPTH];
   bit               m_sweep;
   int               m_pos;

   gpr_file_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .rd_hit1(rd_hit1), .rd_hit2(rd_hit2),
      .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
      .busy_vec(busy_vec), .clr_req(clr_req), .clr_busy(clr_busy)
   );

   gpr_file_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1_nb), .rd_data2(rd_data2_nb),
      .rd_hit1(rd_hit1_nb), .rd_hit2(rd_hit2_nb),
      .rd_busy1(rd_busy1_nb), .rd_busy2(rd_busy2_nb),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_nb),
      .busy_vec(busy_vec_nb), .clr_req(clr_req), .clr_busy(clr_busy_nb)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   function automatic bit m_in(input logic [ADDR_W-1:0] a);
      return int'(a) < DEPTH;
   endfunction

   function automatic bit m_wr_acc();
      return wr_en && m_in(wr_addr) && !m_sweep;
   endfunction

   function automatic bit m_rsv_acc();
      return rsv_en && m_in(rsv_addr) && !m_busy[int'(rsv_addr) % DEPTH] && !m_sweep;
   endfunction

   function automatic logic [WIDTH-1:0] m_read(input logic [ADDR_W-1:0] a, input bit byp);
      if (!m_in(a)) return '0;
      if (byp && m_wr_acc() && wr_addr == a) return wr_data;
      return m_mem[int'(a)];
   endfunction

   function automatic logic [DEPTH-1:0] m_busy_vec();
      logic [DEPTH-1:0] v;
      for (int i = 0; i < DEPTH; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
      m_sweep = 1'b0;
      m_pos   = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      bit wok, rok;
      wok = m_wr_acc();
      rok = m_rsv_acc();
      if (m_sweep) begin
         m_mem[m_pos]  = '0;
         m_busy[m_pos] = 1'b0;
         m_pos++;
         if (m_pos == DEPTH) m_sweep = 1'b0;
      end else begin
         if (wok) begin
            m_mem[int'(wr_addr)]  = wr_data;
            m_busy[int'(wr_addr)] = 1'b0;
         end
         if (rok) m_busy[int'(rsv_addr)] = 1'b1;
         if (clr_req) begin
            m_sweep = 1'b1;
            m_pos   = 0;
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rd_addr1 = '0; rd_addr2 = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rsv_en = 1'b0; rsv_addr = '0;
      clr_req = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      cyc();
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, 15));
      return ADDR_W'($urandom_range(0, DEPTH - 1));
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_checks++;
      if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL reset_busy_vec: got %h exp 00", busy_vec); end
      n_checks++;
      if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy: got %b exp 0", clr_busy); end
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr1 = ADDR_W'(i);
         rd_addr2 = ADDR_W'(DEPTH - 1 - i);
         #1;
         n_checks++;
         if (rd_data1 !== 8'h00 || rd_hit1 !== 1'b1 || rd_busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read1 r%0d: got data=%h hit=%b busy=%b exp 00/1/0", i, rd_data1, rd_hit1, rd_busy1);
         end
         n_checks++;
         if (rd_data2 !== 8'h00 || rd_hit2 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_read2 r%0d: got data=%h hit=%b exp 00/1", DEPTH - 1 - i, rd_data2, rd_hit2);
         end
      end
      rd_addr1 = 4'b1010;
      rd_addr2 = 4'b1000;
      #1;
      n_checks++;
      if (rd_hit1 !== 1'b0 || rd_data1 !== 8'h00) begin
         n_fail++; $display("FAIL periph_read_1010: got hit=%b data=%h exp 0/00", rd_hit1, rd_data1);
      end
      n_checks++;
      if (rd_hit2 !== 1'b0 || rd_data2 !== 8'h00) begin
         n_fail++; $display("FAIL periph_read_1000: got hit=%b data=%h exp 0/00", rd_hit2, rd_data2);
      end
   endtask

   task automatic test_bypass();
      cyc();
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
      rd_addr1 = 4'd3; rd_addr2 = 4'd3;
      #3;
      n_checks++;
      if (rd_data1 !== 8'hA5) begin n_fail++; $display("FAIL bypass_same_cycle: got %h exp a5", rd_data1); end
      n_checks++;
      if (rd_data1_nb !== 8'h00) begin n_fail++; $display("FAIL nobypass_same_cycle: got %h exp 00", rd_data1_nb); end
      n_checks++;
      if (rd_data2 !== 8'hA5) begin n_fail++; $display("FAIL bypass_port2: got %h exp a5", rd_data2); end
      cyc();
      wr_en = 1'b0;
      #3;
      n_checks++;
      if (rd_data1 !== 8'hA5) begin n_fail++; $display("FAIL bypass_next_cycle: got %h exp a5", rd_data1); end
      n_checks++;
      if (rd_data1_nb !== 8'hA5) begin n_fail++; $display("FAIL nobypass_next_cycle: got %h exp a5", rd_data1_nb); end
      // A write into the peripheral space must neither forward nor hit.
      wr_en = 1'b1; wr_addr = 4'b1011; wr_data = 8'h5A; rd_addr1 = 4'b1011;
      #1;
      n_checks++;
      if (rd_data1 !== 8'h00) begin n_fail++; $display("FAIL bypass_out_of_range: got %h exp 00", rd_data1); end
      wr_en = 1'b0;
   endtask

   task automatic test_scoreboard();
      cyc();
      rsv_en = 1'b1; rsv_addr = 4'd5;
      #3;
      n_checks++;
      if (rsv_ok !== 1'b1) begin n_fail++; $display("FAIL rsv_first: got %b exp 1", rsv_ok); end
      cyc();
      rd_addr2 = 4'd5;
      #3;
      n_checks++;
      if (busy_vec !== 8'h20) begin n_fail++; $display("FAIL rsv_busy_vec: got %h exp 20", busy_vec); end
      n_checks++;
      if (rsv_ok !== 1'b0) begin n_fail++; $display("FAIL rsv_waw_stall: got %b exp 0", rsv_ok); end
      n_checks++;
      if (rd_busy2 !== 1'b1) begin n_fail++; $display("FAIL rd_busy_r5: got %b exp 1", rd_busy2); end
      rsv_addr = 4'b1101;
      #1;
      n_checks++;
      if (rsv_ok !== 1'b0) begin n_fail++; $display("FAIL rsv_out_of_range: got %b exp 0", rsv_ok); end
      cyc();
      rsv_en = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h42;
      rd_addr1 = 4'd5; rd_addr2 = 4'd1;
      #3;
      n_checks++;
      if (rd_busy1 !== 1'b1 || rd_busy2 !== 1'b0 || rd_data2 !== 8'h42) begin
         n_fail++;
         $display("FAIL busy_vs_bypass: got busy1=%b busy2=%b data2=%h exp 1/0/42", rd_busy1, rd_busy2, rd_data2);
      end
      cyc();
      wr_addr = 4'd5; wr_data = 8'h11;
      #3;
      n_checks++;
      if (rd_busy1 !== 1'b1) begin n_fail++; $display("FAIL busy_not_masked: got %b exp 1", rd_busy1); end
      cyc();
      wr_en = 1'b0;
      #3;
      n_checks++;
      if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL write_clears_busy: got %h exp 00", busy_vec); end
      cyc();
      rsv_en = 1'b1; rsv_addr = 4'd5;
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h3C;
      #3;
      n_checks++;
      if (rsv_ok !== 1'b1) begin n_fail++; $display("FAIL rsv_with_write: got %b exp 1", rsv_ok); end
      cyc();
      rsv_en = 1'b0; wr_en = 1'b0;
      rd_addr1 = 4'd5; rd_addr2 = 4'd1;
      #3;
      n_checks++;
      if (busy_vec !== 8'h20) begin n_fail++; $display("FAIL rsv_wins_over_write: got %h exp 20", busy_vec); end
      n_checks++;
      if (rd_data1 !== 8'h3C) begin n_fail++; $display("FAIL r5_data: got %h exp 3c", rd_data1); end
      n_checks++;
      if (rd_data2 !== 8'h42) begin n_fail++; $display("FAIL r1_data: got %h exp 42", rd_data2); end
   endtask

   task automatic test_clear();
      int n_hi;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = 8'(17 * (i + 1));
         cyc();
      end
      wr_en = 1'b0;
      rsv_en = 1'b1; rsv_addr = 4'd2;
      cyc();
      rsv_en = 1'b0;
      #3;
      n_checks++;
      if (busy_vec !== 8'h04) begin n_fail++; $display("FAIL pre_clear_busy: got %h exp 04", busy_vec); end
      clr_req = 1'b1;
      cyc();
      // Keep clr_req high into the sweep; it must not restart the count.
      rsv_en = 1'b1; rsv_addr = 4'd0;
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h99;
      rd_addr2 = 4'd7;
      n_hi = 0;
      for (int i = 0; i < 16; i++) begin
         #3;
         if (clr_busy === 1'b1) begin
            n_hi++;
            n_checks++;
            if (rsv_ok !== 1'b0) begin n_fail++; $display("FAIL rsv_during_sweep c%0d: got %b exp 0", n_hi, rsv_ok); end
            n_checks++;
            if (rd_data2 !== 8'h88) begin n_fail++; $display("FAIL r7_write_dropped c%0d: got %h exp 88", n_hi, rd_data2); end
         end else begin
            rsv_en = 1'b0; wr_en = 1'b0;
            break;
         end
         if (i == 2) clr_req = 1'b0;
         cyc();
      end
      rsv_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
      n_checks++;
      if (n_hi !== 8) begin n_fail++; $display("FAIL sweep_length: got %0d exp 8", n_hi); end
      #1;
      n_checks++;
      if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL post_clear_busy: got %h exp 00", busy_vec); end
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr1 = ADDR_W'(i);
         #1;
         n_checks++;
         if (rd_data1 !== 8'h00) begin n_fail++; $display("FAIL post_clear_r%0d: got %h exp 00", i, rd_data1); end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n_hi;
      do_reset();
      wr_en = 1'b1; wr_addr = 4'd6; wr_data = 8'h77;
      cyc();
      wr_en = 1'b0; clr_req = 1'b1;
      cyc();
      clr_req = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      rd_addr1 = 4'd6; rd_addr2 = 4'd0;
      #2;
      n_checks++;
      if (clr_busy !== 1'b1 || rd_data1 !== 8'h77 || rd_data2 !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_sweep_state: got clr_busy=%b r6=%h r0=%h exp 1/77/00", clr_busy, rd_data1, rd_data2);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_clr_busy: got %b exp 0", clr_busy); end
      n_checks++;
      if (rd_data1 !== 8'h00 || busy_vec !== 8'h00) begin
         n_fail++; $display("FAIL async_reset_state: got r6=%h busy=%h exp 00/00", rd_data1, busy_vec);
      end
      #2;
      rst_n = 1'b1;
      cyc();
      wr_en = 1'b1; wr_addr = 4'd6; wr_data = 8'h77;
      cyc();
      wr_en = 1'b0; clr_req = 1'b1;
      cyc();
      clr_req = 1'b0;
      n_hi = 0;
      for (int i = 0; i < 16; i++) begin
         #3;
         if (clr_busy === 1'b1) n_hi++;
         else break;
         cyc();
      end
      n_checks++;
      if (n_hi !== 8) begin n_fail++; $display("FAIL fresh_sweep_length: got %0d exp 8", n_hi); end
      #1;
      n_checks++;
      if (rd_data1 !== 8'h00) begin n_fail++; $display("FAIL fresh_sweep_r6: got %h exp 00", rd_data1); end
   endtask

   task automatic test_random();
      logic [DEPTH-1:0] e_bv;
      logic [WIDTH-1:0] e_d1, e_d2, e_d1n, e_d2n;
      bit e_h1, e_h2, e_b1, e_b2, e_rok;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rd_addr1 = rand_addr();
         rd_addr2 = rand_addr();
         wr_en    = 1'($urandom_range(0, 1));
         wr_addr  = rand_addr();
         wr_data  = 8'($urandom_range(0, 255));
         rsv_en   = 1'($urandom_range(0, 1));
         rsv_addr = rand_addr();
         clr_req  = ($urandom_range(0, 39) == 0);
         #3;
         e_d1  = m_read(rd_addr1, 1'b1);
         e_d2  = m_read(rd_addr2, 1'b1);
         e_d1n = m_read(rd_addr1, 1'b0);
         e_d2n = m_read(rd_addr2, 1'b0);
         e_h1  = m_in(rd_addr1);
         e_h2  = m_in(rd_addr2);
         e_b1  = e_h1 && m_busy[int'(rd_addr1) % DEPTH];
         e_b2  = e_h2 && m_busy[int'(rd_addr2) % DEPTH];
         e_rok = m_rsv_acc();
         e_bv  = m_busy_vec();
         n_checks++;
         if (rd_data1 !== e_d1 || rd_data2 !== e_d2) begin
            n_fail++; $display("FAIL rand_rd_data c%0d: got %h/%h exp %h/%h", c, rd_data1, rd_data2, e_d1, e_d2);
         end
         n_checks++;
         if ({rd_hit1, rd_hit2, rd_busy1, rd_busy2} !== {e_h1, e_h2, e_b1, e_b2}) begin
            n_fail++;
            $display("FAIL rand_hit_busy c%0d: got %b%b%b%b exp %b%b%b%b", c,
                     rd_hit1, rd_hit2, rd_busy1, rd_busy2, e_h1, e_h2, e_b1, e_b2);
         end
         n_checks++;
         if (rsv_ok !== e_rok || busy_vec !== e_bv || clr_busy !== m_sweep) begin
            n_fail++;
            $display("FAIL rand_sb c%0d: got rsv_ok=%b busy=%h clr=%b exp %b/%h/%b", c,
                     rsv_ok, busy_vec, clr_busy, e_rok, e_bv, m_sweep);
         end
         n_checks++;
         if ({rd_data1_nb, rd_data2_nb, rd_hit1_nb, rd_hit2_nb, rd_busy1_nb, rd_busy2_nb,
              rsv_ok_nb, busy_vec_nb, clr_busy_nb} !==
             {e_d1n, e_d2n, e_h1, e_h2, e_b1, e_b2, e_rok, e_bv, m_sweep}) begin
            n_fail++;
            $display("FAIL rand_nobypass c%0d: got d=%h/%h busy=%h exp d=%h/%h busy=%h", c,
                     rd_data1_nb, rd_data2_nb, busy_vec_nb, e_d1n, e_d2n, e_bv);
         end
         model_step();
         cyc();
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      test_reset();
      test_bypass();
      test_scoreboard();
      test_clear();
      test_reset_mid_sweep();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
Parametrised general-purpose register file with two combinational read ports and one registered write port. Adds write-to-read bypass, a per-register scoreboard (pending-write tracking for hazard stalls) and a sequenced bulk-clear engine. Sits inside the CPU between decode/issue and the ALU. Peripheral registers are decoded at top level.

Parameters:
WIDTH, 8, register data width in bits
DEPTH, 8, number of GPRs; must be a power of 2 and at most 2^(ADDR_W-1)
ADDR_W, 4, register address width; MSB set selects the peripheral space
BYPASS, 1, 1 forwards a same-cycle write to the read ports; 0 disables forwarding

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr1  in  ADDR_W  operand 1 register address
rd_addr2  in  ADDR_W  operand 2 register address
rd_data1  out  WIDTH  operand 1 data
rd_data2  out  WIDTH  operand 2 data
rd_hit1  out  1  rd_addr1 decodes to a GPR
rd_hit2  out  1  rd_addr2 decodes to a GPR
rd_busy1  out  1  rd_addr1 GPR has a pending write (RAW hazard)
rd_busy2  out  1  rd_addr2 GPR has a pending write
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write destination
wr_data  in  WIDTH  write data
rsv_en  in  1  reserve destination at issue
rsv_addr  in  ADDR_W  destination to reserve
rsv_ok  out  1  reservation accepted this cycle
busy_vec  out  DEPTH  scoreboard bits, bit i = GPR i pending
clr_req  in  1  request a bulk clear of all GPRs and scoreboard
clr_busy  out  1  clear sweep in progress

Behaviour:
- Reset: rst_n low is asynchronous. All GPRs become 0, busy_vec becomes 0, the FSM goes to IDLE, the sweep index becomes 0 and clr_busy becomes 0. Reset has effect mid-sweep and mid-write.
- GPR decode: address is in range when MSB = 0 and addr[ADDR_W-2:0] < DEPTH. Out-of-range addresses are never written or reserved.
- Read (combinational, 0 latency):
  - rd_hitN = in-range(rd_addrN).
  - rd_dataN = 0 when not hit. The port is never tri-stated; the top level muxes the peripheral space.
  - When BYPASS=1, wr_en=1, the write is accepted and wr_addr==rd_addrN (hit), rd_dataN = wr_data. Otherwise rd_dataN = stored value.
  - rd_busyN = hit & busy[rd_addrN]. Bypass does not mask busy; busy reflects the registered state.
- Write: an accepted write (wr_en & in-range & !clr_busy) updates the GPR at the next rising edge. Write data is visible from storage one cycle after the strobe. Writes while clr_busy=1 are dropped.
- Scoreboard:
  - rsv_ok = rsv_en & in-range(rsv_addr) & !busy[rsv_addr] & !clr_busy. This is combinational.
  - rsv_ok=1 sets busy[rsv_addr] at the edge.
  - An accepted write clears busy[wr_addr] at the edge.
  - If a reservation and a write target the same address in the same cycle, the reservation wins and busy stays 1. This is a new pending writer.
  - A reservation of an already-busy register gives rsv_ok=0 with no state change (WAW stall). The issuer must hold.
  - A write to a non-busy register is legal and leaves busy at 0.
- Clear FSM, states IDLE and SWEEP:
  - IDLE: clr_req=1 moves to SWEEP at the next edge with idx=0. clr_busy is 1 in SWEEP only.
  - SWEEP: each cycle data[idx]<=0 and busy[idx]<=0, then idx increments. When idx==DEPTH-1 the FSM returns to IDLE after that cycle's clear. A sweep takes exactly DEPTH cycles.
  - clr_req during SWEEP is ignored and does not restart the sweep.
  - Reads during SWEEP return the current storage and may mix cleared and uncleared registers; the consumer must stall on clr_busy.

Test Plan:
- Reset then read all 8 addresses -> rd_data=0x00, rd_hit=1, busy_vec=0x00; read address 4'b1010 -> rd_hit=0, rd_data=0x00.
- Write 0xA5 to r3, reading r3 in the same cycle -> BYPASS=1 gives rd_data1=0xA5 that cycle; BYPASS=0 gives the old 0x00 that cycle and 0xA5 the next.
- rsv r5 -> rsv_ok=1 and busy_vec=0x20 next cycle; rsv r5 again -> rsv_ok=0; write r5 with 0x3C while rsv r5 -> busy_vec stays 0x20 and r5=0x3C.
- Load r0..r7 with 0x11..0x88, busy r2, pulse clr_req -> clr_busy high for exactly 8 cycles. A write to r7 during the sweep is dropped. Afterwards all GPRs=0x00, busy_vec=0x00, and rsv_ok=0 throughout the sweep.
- Assert rst_n low mid-sweep (idx=4) with r6=0x77 -> clr_busy drops immediately and all GPRs=0x00; after release, clr_req starts a fresh sweep from idx=0.
